mem_lsu_ctrl: RTL

MEM_LSU_CTRL -- requirements
Module: mem_lsu_ctrl

---
 rtl/mem_lsu_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_lsu_ctrl.sv
// M-stage load/store controller: decodes the instruction in M, stalls the pipeline and runs the memory handshake.
// Optional MISALIGN_EXC_EN: raises adel/ades and suppresses the access on misaligned lw/lh/lhu/sw/sh.
module mem_lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TO_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IR,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_rdy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic              stall,
    output logic              CP0_WE,
    output logic              EXL_clr,
    output logic              CP0_sel,
    output logic              SL,
    output logic              is_lw,
    output logic              adel,
    output logic              ades,
    output logic              timeout,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY cycle in which the counter may still be waiting; one more miss hits 2^TO_W-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

    state_t          state, state_nxt;
    logic [TO_W-1:0] cnt;
    logic [3:0]      be_q;
    logic            we_q;

    logic [5:0] op;
    logic       op_lb, op_lh, op_lw, op_lbu, op_lhu, op_sb, op_sh, op_sw;
    logic       op_load, op_store, op_cop0;
    logic [3:0] be_comb;
    logic       adel_raw, ades_raw;
    logic       launch, req_c, we_c, stall_c, to_c;
    logic       unused_bits;

    assign op       = IR[31:26];
    assign op_lb    = (op == 6'h20);
    assign op_lh    = (op == 6'h21);
    assign op_lw    = (op == 6'h23);
    assign op_lbu   = (op == 6'h24);
    assign op_lhu   = (op == 6'h25);
    assign op_sb    = (op == 6'h28);
    assign op_sh    = (op == 6'h29);
    assign op_sw    = (op == 6'h2B);
    assign op_load  = op_lb | op_lh | op_lw | op_lbu | op_lhu;
    assign op_store = op_sb | op_sh | op_sw;
    assign op_cop0  = (op == 6'h10);

    assign SL      = valid & (op_load | op_store);
    assign is_lw   = valid & op_lw;
    assign CP0_WE  = valid & op_cop0 & (IR[25:21] == 5'b00100);
    assign CP0_sel = valid & op_cop0 & (IR[25:21] == 5'b00000);
    assign EXL_clr = valid & op_cop0 & IR[25] & (IR[5:0] == 6'h18);

    assign unused_bits = ^{addr[ADDR_W-1:2], IR[20:6]};

    always_comb begin
        be_comb = 4'b0000;
        if (valid) begin
            if (op_lw | op_sw)
                be_comb = 4'b1111;
            else if (op_lh | op_lhu | op_sh)
                be_comb = addr[1] ? 4'b1100 : 4'b0011;
            else if (op_lb | op_lbu | op_sb)
                be_comb = 4'b0001 << addr[1:0];
        end
    end

`ifdef MISALIGN_EXC_EN
    assign adel_raw = valid & ((op_lw & (addr[1:0] != 2'b00)) | ((op_lh | op_lhu) & addr[0]));
    assign ades_raw = valid & ((op_sw & (addr[1:0] != 2'b00)) | (op_sh & addr[0]));
`else
    assign adel_raw = 1'b0;
    assign ades_raw = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            be_q  <= 4'b0000;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                cnt  <= '0;
                be_q <= be_comb;
                we_q <= op_store;
            end else if (state == BUSY && !mem_rdy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // mem_rdy beats the timeout when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        to_c      = 1'b0;
        case (state)
            IDLE: begin
                if (SL && !(adel_raw || ades_raw)) begin
                    launch    = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_rdy) begin
                    req_c     = 1'b1;
                    we_c      = we_q;
                    state_nxt = DONE;
                end else if (cnt == TO_LAST) begin
                    to_c      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    req_c   = 1'b1;
                    we_c    = we_q;
                    stall_c = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, independent of the clock.
    assign mem_req   = reset & req_c;
    assign mem_we    = reset & we_c;
    assign stall     = reset & stall_c;
    assign timeout   = reset & to_c;
    assign mem_be    = (state == BUSY) ? be_q : be_comb;
    assign adel      = (state == BUSY) ? 1'b0 : adel_raw;
    assign ades      = (state == BUSY) ? 1'b0 : ades_raw;
    assign fsm_state = state;

endmodule
